// File: rtl/tlb_entry_file.sv
// Purpose : 16-entry TLB register file with TLBWI/TLBWR/TLBR and the CP0 Random/Wired pair.
// Latency : writes visible on tlb_entryN one cycle after the strobe; TLBR data valid one cycle later.
// Backpressure: none; every strobe is accepted in the cycle it is presented.
module tlb_entry_file #(
    parameter int NUM_ENTRIES = 16,
    parameter logic [3:0] RANDOM_TOP = 4'd15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tlbwi,
    input  logic        tlbwr,
    input  logic        tlbr,
    input  logic [3:0]  index_in,
    input  logic [31:0] entry_hi_in,
    input  logic [31:0] entry_lo0_in,
    input  logic [31:0] entry_lo1_in,
    input  logic        wired_we,
    input  logic [3:0]  wired_in,
    output logic [79:0] tlb_entry0,
    output logic [79:0] tlb_entry1,
    output logic [79:0] tlb_entry2,
    output logic [79:0] tlb_entry3,
    output logic [79:0] tlb_entry4,
    output logic [79:0] tlb_entry5,
    output logic [79:0] tlb_entry6,
    output logic [79:0] tlb_entry7,
    output logic [79:0] tlb_entry8,
    output logic [79:0] tlb_entry9,
    output logic [79:0] tlb_entry10,
    output logic [79:0] tlb_entry11,
    output logic [79:0] tlb_entry12,
    output logic [79:0] tlb_entry13,
    output logic [79:0] tlb_entry14,
    output logic [79:0] tlb_entry15,
    output logic        rd_valid,
    output logic [31:0] rd_entry_hi,
    output logic [31:0] rd_entry_lo0,
    output logic [31:0] rd_entry_lo1,
    output logic [3:0]  random_out,
    output logic [3:0]  wired_out
);

    logic [NUM_ENTRIES-1:0][79:0] entry_q;
    logic [3:0]  random_q, random_d;
    logic [3:0]  wired_q, wired_d;
    logic        rd_valid_q;
    logic [31:0] rd_hi_q, rd_lo0_q, rd_lo1_q;

    logic        wr_en;
    logic [3:0]  wr_idx;
    logic [79:0] wr_entry;
    logic [79:0] rd_sel;

    // Build the packed entry from the CP0 registers; TLBWI wins over TLBWR on the index.
    always_comb begin
        wr_en    = tlbwi | tlbwr;
        wr_idx   = tlbwi ? index_in : random_q;
        wr_entry = {entry_hi_in[7:0],
                    entry_lo0_in[0] & entry_lo1_in[0],
                    entry_hi_in[31:13],
                    entry_lo1_in[29:6], entry_lo1_in[2], entry_lo1_in[1],
                    entry_lo0_in[29:6], entry_lo0_in[2], entry_lo0_in[1]};
        rd_sel   = entry_q[index_in];
    end

    // Random steps down toward Wired and wraps to the top; a Wired write restarts it.
    always_comb begin
        wired_d  = wired_q;
        random_d = random_q - 4'd1;
        if (wired_we) begin
            wired_d  = wired_in;
            random_d = RANDOM_TOP;
        end else if (random_q == wired_q) begin
            random_d = RANDOM_TOP;
        end
    end

    // Entry array: a single entry is replaced on a write strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_q <= '0;
        end else if (wr_en) begin
            entry_q[wr_idx] <= wr_entry;
        end
    end

    // Random and Wired registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            random_q <= RANDOM_TOP;
            wired_q  <= 4'd0;
        end else begin
            random_q <= random_d;
            wired_q  <= wired_d;
        end
    end

    // TLBR read port: samples the pre-write array, holds data until the next read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_hi_q    <= '0;
            rd_lo0_q   <= '0;
            rd_lo1_q   <= '0;
        end else begin
            rd_valid_q <= tlbr;
            if (tlbr) begin
                rd_hi_q  <= {rd_sel[70:52], 5'd0, rd_sel[79:72]};
                rd_lo0_q <= {2'd0, rd_sel[25:2], 3'd0, rd_sel[1], rd_sel[0], rd_sel[71]};
                rd_lo1_q <= {2'd0, rd_sel[51:28], 3'd0, rd_sel[27], rd_sel[26], rd_sel[71]};
            end
        end
    end

    assign rd_valid     = rd_valid_q;
    assign rd_entry_hi  = rd_hi_q;
    assign rd_entry_lo0 = rd_lo0_q;
    assign rd_entry_lo1 = rd_lo1_q;
    assign random_out   = random_q;
    assign wired_out    = wired_q;

    assign tlb_entry0  = entry_q[0];
    assign tlb_entry1  = entry_q[1];
    assign tlb_entry2  = entry_q[2];
    assign tlb_entry3  = entry_q[3];
    assign tlb_entry4  = entry_q[4];
    assign tlb_entry5  = entry_q[5];
    assign tlb_entry6  = entry_q[6];
    assign tlb_entry7  = entry_q[7];
    assign tlb_entry8  = entry_q[8];
    assign tlb_entry9  = entry_q[9];
    assign tlb_entry10 = entry_q[10];
    assign tlb_entry11 = entry_q[11];
    assign tlb_entry12 = entry_q[12];
    assign tlb_entry13 = entry_q[13];
    assign tlb_entry14 = entry_q[14];
    assign tlb_entry15 = entry_q[15];

endmodule

// File: tb/tb_tlb_entry_file.sv
// Purpose : randomized + directed bench for tlb_entry_file against a field-level reference model.
// Latency : model advances on each rising edge; outputs compared on every falling edge.
// Backpressure: not applicable.
module tb_tlb_entry_file;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tlbwi = 1'b0, tlbwr = 1'b0, tlbr = 1'b0;
    logic [3:0]  index_in = '0;
    logic [31:0] entry_hi_in = '0, entry_lo0_in = '0, entry_lo1_in = '0;
    logic        wired_we = 1'b0;
    logic [3:0]  wired_in = '0;
    logic [15:0][79:0] dut_e;
    logic        rd_valid;
    logic [31:0] rd_entry_hi, rd_entry_lo0, rd_entry_lo1;
    logic [3:0]  random_out, wired_out;

    always #5 clk = ~clk;

    tlb_entry_file dut (
        .clk(clk), .rst(rst), .tlbwi(tlbwi), .tlbwr(tlbwr), .tlbr(tlbr),
        .index_in(index_in), .entry_hi_in(entry_hi_in),
        .entry_lo0_in(entry_lo0_in), .entry_lo1_in(entry_lo1_in),
        .wired_we(wired_we), .wired_in(wired_in),
        .tlb_entry0(dut_e[0]),   .tlb_entry1(dut_e[1]),   .tlb_entry2(dut_e[2]),
        .tlb_entry3(dut_e[3]),   .tlb_entry4(dut_e[4]),   .tlb_entry5(dut_e[5]),
        .tlb_entry6(dut_e[6]),   .tlb_entry7(dut_e[7]),   .tlb_entry8(dut_e[8]),
        .tlb_entry9(dut_e[9]),   .tlb_entry10(dut_e[10]), .tlb_entry11(dut_e[11]),
        .tlb_entry12(dut_e[12]), .tlb_entry13(dut_e[13]), .tlb_entry14(dut_e[14]),
        .tlb_entry15(dut_e[15]),
        .rd_valid(rd_valid), .rd_entry_hi(rd_entry_hi),
        .rd_entry_lo0(rd_entry_lo0), .rd_entry_lo1(rd_entry_lo1),
        .random_out(random_out), .wired_out(wired_out)
    );

    // Reference model: each entry kept as separate architectural fields.
    logic [7:0]  m_asid [16];
    logic        m_g    [16];
    logic [18:0] m_vpn2 [16];
    logic [23:0] m_pfn0 [16], m_pfn1 [16];
    logic        m_d0 [16], m_v0 [16], m_d1 [16], m_v1 [16];
    int          m_random, m_wired;
    logic        m_rd_vld;
    logic [31:0] m_rd_hi, m_rd_lo0, m_rd_lo1;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [79:0] m_entry(input int i);
        return {m_asid[i], m_g[i], m_vpn2[i], m_pfn1[i], m_d1[i], m_v1[i],
                m_pfn0[i], m_d0[i], m_v0[i]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_asid[i] = '0; m_g[i] = 1'b0; m_vpn2[i] = '0; m_pfn0[i] = '0; m_pfn1[i] = '0;
            m_d0[i] = 1'b0; m_v0[i] = 1'b0; m_d1[i] = 1'b0; m_v1[i] = 1'b0;
        end
        m_random = 15; m_wired = 0;
        m_rd_vld = 1'b0; m_rd_hi = '0; m_rd_lo0 = '0; m_rd_lo1 = '0;
    endtask

    // One clock edge of architectural behaviour, using the inputs held across the edge.
    task automatic model_update();
        int idx;
        if (rst) return;
        m_rd_vld = tlbr;
        if (tlbr) begin
            idx = int'(index_in);
            m_rd_hi  = (32'(m_vpn2[idx]) << 13) | 32'(m_asid[idx]);
            m_rd_lo0 = (32'(m_pfn0[idx]) << 6) | (32'(m_d0[idx]) << 2) | (32'(m_v0[idx]) << 1) | 32'(m_g[idx]);
            m_rd_lo1 = (32'(m_pfn1[idx]) << 6) | (32'(m_d1[idx]) << 2) | (32'(m_v1[idx]) << 1) | 32'(m_g[idx]);
        end
        if (tlbwi || tlbwr) begin
            idx = tlbwi ? int'(index_in) : m_random;
            m_asid[idx] = entry_hi_in[7:0];
            m_vpn2[idx] = entry_hi_in[31:13];
            m_g[idx]    = entry_lo0_in[0] && entry_lo1_in[0];
            m_pfn0[idx] = entry_lo0_in[29:6]; m_d0[idx] = entry_lo0_in[2]; m_v0[idx] = entry_lo0_in[1];
            m_pfn1[idx] = entry_lo1_in[29:6]; m_d1[idx] = entry_lo1_in[2]; m_v1[idx] = entry_lo1_in[1];
        end
        if (wired_we) begin
            m_wired = int'(wired_in); m_random = 15;
        end else if (m_random == m_wired) begin
            m_random = 15;
        end else begin
            m_random = m_random - 1;
        end
    endtask

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 16; i++) chk($sformatf("entry%0d", i), dut_e[i], m_entry(i));
            chk("rd_valid", 80'(rd_valid), 80'(m_rd_vld));
            chk("rd_entry_hi", 80'(rd_entry_hi), 80'(m_rd_hi));
            chk("rd_entry_lo0", 80'(rd_entry_lo0), 80'(m_rd_lo0));
            chk("rd_entry_lo1", 80'(rd_entry_lo1), 80'(m_rd_lo1));
            chk("random_out", 80'(random_out), 80'(m_random));
            chk("wired_out", 80'(wired_out), 80'(m_wired));
        end
    end

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        tlbwi = 1'b0; tlbwr = 1'b0; tlbr = 1'b0; wired_we = 1'b0;
    endtask

    initial begin
        bit found;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // Idle after reset: Random counts 15 down to 0 and wraps.
        for (int k = 0; k < 20; k++) begin
            chk("idle_random_lit", 80'(random_out), 80'((15 - k) & 15));
            step();
        end

        // Wired = 12: Random restarts at 15 and cycles 15..12.
        wired_we = 1'b1; wired_in = 4'd12;
        step();
        idle_inputs();
        for (int j = 0; j < 6; j++) begin
            chk("wired12_random_lit", 80'(random_out), 80'(15 - (j % 4)));
            step();
        end
        chk("wired_lit", 80'(wired_out), 80'd12);

        // TLBWI to entry 5.
        tlbwi = 1'b1; index_in = 4'd5;
        entry_hi_in = 32'h0040_2012; entry_lo0_in = 32'h0000_1047; entry_lo1_in = 32'h0000_1086;
        step();
        idle_inputs();
        chk("entry5_lit", dut_e[5], {8'h12, 1'b0, 19'h00201, 24'h42, 1'b1, 1'b1, 24'h41, 1'b1, 1'b1});

        // TLBWI and TLBWR together while Random is 9: only entry 3 changes.
        wired_we = 1'b1; wired_in = 4'd0;
        step();
        idle_inputs();
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (m_random == 9) found = 1'b1;
            else step();
        end
        chk("reach_random9", 80'(found), 80'd1);
        chk("random9_lit", 80'(random_out), 80'd9);
        tlbwi = 1'b1; tlbwr = 1'b1; index_in = 4'd3;
        entry_hi_in = 32'hABCD_E0FF; entry_lo0_in = 32'h3FFF_FFC3; entry_lo1_in = 32'hC000_0047;
        step();
        idle_inputs();
        chk("entry9_untouched_lit", dut_e[9], 80'd0);
        chk("entry3_written_lit", 80'(dut_e[3] != 80'd0), 80'd1);

        // TLBR racing TLBWI on entry 5 returns the old entry, a second read the new one.
        tlbr = 1'b1; tlbwi = 1'b1; index_in = 4'd5;
        entry_hi_in = 32'h1234_6055; entry_lo0_in = 32'h0000_0803; entry_lo1_in = 32'h0000_0841;
        step();
        idle_inputs();
        chk("rbw_valid_lit", 80'(rd_valid), 80'd1);
        chk("rbw_hi_lit",  80'(rd_entry_hi),  80'h0040_2012);
        chk("rbw_lo0_lit", 80'(rd_entry_lo0), 80'h0000_1046);
        chk("rbw_lo1_lit", 80'(rd_entry_lo1), 80'h0000_1086);
        tlbr = 1'b1; index_in = 4'd5;
        step();
        idle_inputs();
        chk("rd2_hi_lit",  80'(rd_entry_hi),  80'h1234_6055);
        chk("rd2_lo0_lit", 80'(rd_entry_lo0), 80'h0000_0803);
        chk("rd2_lo1_lit", 80'(rd_entry_lo1), 80'h0000_0841);
        step();
        chk("rd_valid_pulse_lit", 80'(rd_valid), 80'd0);
        chk("rd_hold_lit", 80'(rd_entry_hi), 80'h1234_6055);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            tlbwi    = ($urandom_range(0, 3) == 0);
            tlbwr    = ($urandom_range(0, 3) == 0);
            tlbr     = ($urandom_range(0, 2) == 0);
            wired_we = ($urandom_range(0, 19) == 0);
            wired_in = 4'($urandom_range(0, 15));
            index_in = 4'($urandom_range(0, 15));
            entry_hi_in  = $urandom;
            entry_lo0_in = $urandom;
            entry_lo1_in = $urandom;
            step();
        end
        idle_inputs();
        step();

        // Reset asserted in the middle of a TLBWR cycle.
        tlbwr = 1'b1; entry_hi_in = 32'hFFFF_FFFF; entry_lo0_in = 32'hFFFF_FFFF; entry_lo1_in = 32'hFFFF_FFFF;
        #2;
        rst = 1'b1;
        model_reset();
        step();
        idle_inputs();
        chk("rst_random_lit", 80'(random_out), 80'd15);
        chk("rst_wired_lit", 80'(wired_out), 80'd0);
        chk("rst_entries_lit", 80'(dut_e != '0), 80'd0);
        chk("rst_rdvalid_lit", 80'(rd_valid), 80'd0);
        #1;
        rst = 1'b0;
        repeat (3) step();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
